// File: rtl/irq_fast_ctrl_pkg.sv
// Shared register offsets and vector type for the fast-interrupt controller.
package irq_fast_ctrl_pkg;

  localparam int IRQ_NUM_SRC_MAX = 15;

  localparam logic [3:0] IRQ_REG_PENDING  = 4'd0;
  localparam logic [3:0] IRQ_REG_ENABLE   = 4'd1;
  localparam logic [3:0] IRQ_REG_MODE     = 4'd2;
  localparam logic [3:0] IRQ_REG_POLARITY = 4'd3;
  localparam logic [3:0] IRQ_REG_SET      = 4'd4;
  localparam logic [3:0] IRQ_REG_RAW      = 4'd5;
  localparam logic [3:0] IRQ_REG_HIGHEST  = 4'd6;

  typedef logic [14:0] irq_vec_t;

endpackage

// File: rtl/irq_fast_sync.sv
// Per-bit multi-flop synchroniser for asynchronous interrupt sources.
module irq_fast_sync
  import irq_fast_ctrl_pkg::*;
#(
  parameter int WIDTH  = IRQ_NUM_SRC_MAX,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] sync
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= src;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync = stage_q[STAGES-1];

endmodule

// File: rtl/irq_fast_ctrl.sv
// Avalon-MM fast-interrupt controller driving the core's irq_fast_i.
// Optional HIGHEST register at address 6 is built when IRQ_FAST_CTRL_HIGHEST_EN is defined.
module irq_fast_ctrl
  import irq_fast_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [3:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [3:0]         avs_byteenable,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic               avs_waitrequest,
  output logic [NUM_SRC-1:0] irq_fast_o
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] polarity;
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] act_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] wr_bits;
  logic [NUM_SRC-1:0] wr_mask;
  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] pending_next;
  irq_vec_t           wr_mask_full;
  irq_vec_t           wr_bits_full;
  logic               rd_en;
  logic [31:0]        rdata_next;
  logic               unused_bits;

  assign avs_waitrequest = 1'b0;
  // A simultaneous write wins; the read half of the access is dropped.
  assign rd_en = avs_read & ~avs_write;

  assign wr_mask_full = {{7{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign wr_bits_full = avs_writedata[14:0] & wr_mask_full;
  assign wr_mask      = wr_mask_full[NUM_SRC-1:0];
  assign wr_bits      = wr_bits_full[NUM_SRC-1:0];
  assign unused_bits  = ^{avs_writedata[31:15], avs_byteenable[3:2]};

  irq_fast_sync #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .src    (irq_src_i),
    .sync   (sync)
  );

  assign act  = sync ^ polarity;
  assign rise = act & ~act_q;

  assign set_bits = (avs_write && avs_address == IRQ_REG_SET)     ? wr_bits : '0;
  assign clr_bits = (avs_write && avs_address == IRQ_REG_PENDING) ? wr_bits : '0;

  // Edge bits: set beats clear. Level bits just track the active value.
  assign pending_next = (mode & ((pending & ~clr_bits) | rise | set_bits)) |
                        (~mode & act);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      polarity   <= '0;
      act_q      <= '0;
      irq_fast_o <= '0;
    end else begin
      act_q      <= act;
      pending    <= pending_next;
      irq_fast_o <= pending & enable;
      if (avs_write) begin
        case (avs_address)
          IRQ_REG_ENABLE:   enable   <= (enable & ~wr_mask) | wr_bits;
          IRQ_REG_MODE:     mode     <= (mode & ~wr_mask) | wr_bits;
          IRQ_REG_POLARITY: polarity <= (polarity & ~wr_mask) | wr_bits;
          default: ;
        endcase
      end
    end
  end

`ifdef IRQ_FAST_CTRL_HIGHEST_EN
  logic [3:0]  hi_idx;
  logic [31:0] highest;

  // Scan downwards so the lowest-numbered active output is the last to win.
  always_comb begin
    hi_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (irq_fast_o[i]) begin
        hi_idx = 4'(i);
      end
    end
    highest      = '0;
    highest[31]  = |irq_fast_o;
    highest[3:0] = hi_idx;
  end
`endif

  always_comb begin
    rdata_next = '0;
    case (avs_address)
      IRQ_REG_PENDING:  rdata_next[NUM_SRC-1:0] = pending;
      IRQ_REG_ENABLE:   rdata_next[NUM_SRC-1:0] = enable;
      IRQ_REG_MODE:     rdata_next[NUM_SRC-1:0] = mode;
      IRQ_REG_POLARITY: rdata_next[NUM_SRC-1:0] = polarity;
      IRQ_REG_RAW:      rdata_next[NUM_SRC-1:0] = act;
`ifdef IRQ_FAST_CTRL_HIGHEST_EN
      IRQ_REG_HIGHEST:  rdata_next = highest;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      avs_readdatavalid <= rd_en;
      avs_readdata      <= rd_en ? rdata_next : '0;
    end
  end

endmodule

// File: tb/tb_irq_fast_ctrl.sv
// Directed and randomised bench for irq_fast_ctrl, checked against a cycle-level reference model.
module tb_irq_fast_ctrl;

  localparam int NUM_SRC = 15;
  localparam int SYNC    = 2;
`ifdef IRQ_FAST_CTRL_HIGHEST_EN
  localparam logic [31:0] EXP_HIGHEST = 32'h8000_0003;
`else
  localparam logic [31:0] EXP_HIGHEST = 32'h0000_0000;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [NUM_SRC-1:0] irq_src_i = '0;
  logic [3:0]         avs_address = '0;
  logic               avs_read = 1'b0;
  logic               avs_write = 1'b0;
  logic [31:0]        avs_writedata = '0;
  logic [3:0]         avs_byteenable = '0;
  logic [31:0]        avs_readdata;
  logic               avs_readdatavalid;
  logic               avs_waitrequest;
  logic [NUM_SRC-1:0] irq_fast_o;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per clock before the edge
  logic [14:0] m_pend = '0, m_en = '0, m_mode = '0, m_pol = '0, m_act_q = '0, m_out = '0;
  logic [14:0] m_hist [SYNC];
  logic        m_rdv = 1'b0;
  logic [31:0] m_rd = '0;

  always #5 clk_i = ~clk_i;

  irq_fast_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .irq_src_i         (irq_src_i),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .irq_fast_o        (irq_fast_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lowestSet(input logic [14:0] v);
    int idx = 0;
    while (idx < 15 && !v[idx]) idx++;
    return idx;
  endfunction

  function automatic logic [31:0] regValue(input logic [3:0] a, input logic [14:0] act);
    logic [31:0] v = '0;
    case (a)
      4'd0: v = 32'(m_pend);
      4'd1: v = 32'(m_en);
      4'd2: v = 32'(m_mode);
      4'd3: v = 32'(m_pol);
      4'd5: v = 32'(act);
`ifdef IRQ_FAST_CTRL_HIGHEST_EN
      4'd6: if (m_out != 0) v = 32'h8000_0000 | 32'(lowestSet(m_out));
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic modelStep();
    logic [14:0] act, rise, wmask, wbits, nxt;
    if (!rst_ni) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0; m_act_q = '0; m_out = '0;
      m_rdv = 1'b0; m_rd = '0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
      return;
    end
    act   = m_hist[SYNC-1] ^ m_pol;
    rise  = act & ~m_act_q;
    wmask = {{7{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    wbits = avs_writedata[14:0] & wmask;
    m_rdv = avs_read && !avs_write;
    m_rd  = m_rdv ? regValue(avs_address, act) : 32'h0;
    m_out = m_pend & m_en;
    for (int b = 0; b < 15; b++) begin
      if (!m_mode[b])                                         nxt[b] = act[b];
      else if (rise[b] || (avs_write && avs_address == 4 && wbits[b])) nxt[b] = 1'b1;
      else if (avs_write && avs_address == 0 && wbits[b])     nxt[b] = 1'b0;
      else                                                    nxt[b] = m_pend[b];
    end
    if (avs_write) begin
      if (avs_address == 1) m_en   = (m_en & ~wmask) | wbits;
      if (avs_address == 2) m_mode = (m_mode & ~wmask) | wbits;
      if (avs_address == 3) m_pol  = (m_pol & ~wmask) | wbits;
    end
    m_pend  = nxt;
    m_act_q = act;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_src_i;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("irq_model", 32'(irq_fast_o), 32'(m_out));
    checkOutput("rdvalid_model", 32'(avs_readdatavalid), 32'(m_rdv));
    checkOutput("rdata_model", avs_readdata, m_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic r, input logic w,
                               input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_read = r; avs_write = w; avs_writedata = d; avs_byteenable = be;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(a, 1'b0, 1'b1, d, be);
  endtask

  task automatic busRead(input string tag, input logic [3:0] a, input logic [31:0] exp);
    applyStimulus(a, 1'b1, 1'b0, 32'h0, 4'h0);
    checkOutput({tag, "_valid"}, 32'(avs_readdatavalid), 32'h1);
    checkOutput(tag, avs_readdata, exp);
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
    $display("[TB] reset and register defaults");
    idle(2);
    rst_ni = 1'b1;
    checkOutput("reset_irq", 32'(irq_fast_o), 32'h0);
    checkOutput("reset_rdv", 32'(avs_readdatavalid), 32'h0);
    checkOutput("waitrequest", 32'(avs_waitrequest), 32'h0);
    for (int a = 0; a < 6; a++) busRead("reset_read", 4'(a), 32'h0);
    tick();
    checkOutput("rdv_drops", 32'(avs_readdatavalid), 32'h0);
    checkOutput("rdata_drops", avs_readdata, 32'h0);

    $display("[TB] edge mode");
    busWrite(4'd1, 32'h0001, 4'b0011);
    busWrite(4'd2, 32'h0001, 4'b0011);
    irq_src_i[0] = 1'b1;
    tick();
    irq_src_i[0] = 1'b0;
    idle(2);
    checkOutput("edge_early", 32'(irq_fast_o), 32'h0);
    tick();
    checkOutput("edge_latency", 32'(irq_fast_o), 32'h1);
    idle(4);
    checkOutput("edge_sticky", 32'(irq_fast_o), 32'h1);
    busWrite(4'd0, 32'h0001, 4'b0011);
    checkOutput("w1c_lag", 32'(irq_fast_o), 32'h1);
    tick();
    checkOutput("w1c_clear", 32'(irq_fast_o), 32'h0);

    $display("[TB] level mode with inversion");
    busWrite(4'd2, 32'h0, 4'b0011);
    busWrite(4'd3, 32'h0004, 4'b0011);
    busWrite(4'd1, 32'h0004, 4'b0011);
    idle(3);
    checkOutput("level_inv_on", 32'(irq_fast_o), 32'h4);
    irq_src_i[2] = 1'b1;
    idle(3);
    checkOutput("level_inv_hold", 32'(irq_fast_o), 32'h4);
    tick();
    checkOutput("level_inv_off", 32'(irq_fast_o), 32'h0);
    irq_src_i[2] = 1'b0;
    idle(5);
    busWrite(4'd0, 32'h0004, 4'b0011);
    idle(2);
    checkOutput("level_w1c_noeffect", 32'(irq_fast_o), 32'h4);
    busRead("level_pending", 4'd0, 32'h4);
    busRead("raw_inverted", 4'd5, 32'h4);

    $display("[TB] set wins over clear");
    busWrite(4'd3, 32'h0, 4'b0011);
    busWrite(4'd2, 32'h0020, 4'b0011);
    busWrite(4'd1, 32'h0020, 4'b0011);
    busWrite(4'd4, 32'h0020, 4'b0001);
    idle(2);
    checkOutput("set_write_irq", 32'(irq_fast_o), 32'h20);
    irq_src_i[5] = 1'b1;
    idle(2);
    busWrite(4'd0, 32'h0020, 4'b0011);
    busRead("set_wins", 4'd0, 32'h20);
    busWrite(4'd0, 32'h0020, 4'b0011);
    busRead("plain_w1c", 4'd0, 32'h0);
    irq_src_i[5] = 1'b0;
    idle(4);

    $display("[TB] SET with byte enables");
    busWrite(4'd2, 32'h4020, 4'b0011);
    busWrite(4'd1, 32'h4000, 4'b0011);
    busWrite(4'd4, 32'h4000, 4'b0001);
    busRead("set_be_lo", 4'd0, 32'h0);
    busWrite(4'd4, 32'h4000, 4'b0010);
    busRead("set_be_hi", 4'd0, 32'h4000);
    checkOutput("set_be_irq", 32'(irq_fast_o), 32'h4000);
    busRead("set_reads_zero", 4'd4, 32'h0);
    busRead("unmapped_reads_zero", 4'd7, 32'h0);

    $display("[TB] HIGHEST");
    busWrite(4'd2, 32'h0048, 4'b0011);
    busWrite(4'd1, 32'h0048, 4'b0011);
    busWrite(4'd4, 32'h0048, 4'b0001);
    tick();
    checkOutput("highest_irq", 32'(irq_fast_o), 32'h48);
    busRead("highest_active", 4'd6, EXP_HIGHEST);
    busWrite(4'd0, 32'h0048, 4'b0011);
    idle(2);
    busRead("highest_idle", 4'd6, 32'h0);

    $display("[TB] read+write collision and reset mid-operation");
    applyStimulus(4'd1, 1'b1, 1'b1, 32'h0001, 4'b0011);
    checkOutput("rw_collision_rdv", 32'(avs_readdatavalid), 32'h0);
    busRead("rw_collision_write", 4'd1, 32'h1);
    rst_ni = 1'b0;
    applyStimulus(4'd1, 1'b1, 1'b0, 32'h0, 4'h0);
    checkOutput("reset_read_rdv", 32'(avs_readdatavalid), 32'h0);
    rst_ni = 1'b1;
    busRead("reset_cleared_enable", 4'd1, 32'h0);

    $display("[TB] randomised traffic");
    for (int n = 0; n < 600; n++) begin
      int op;
      if ($urandom_range(0, 2) == 0) irq_src_i = 15'($urandom);
      rst_ni         = ($urandom_range(0, 99) != 0);
      op             = int'($urandom_range(0, 9));
      avs_address    = 4'($urandom_range(0, 7));
      avs_writedata  = $urandom;
      avs_byteenable = 4'($urandom);
      avs_read       = (op >= 4 && op <= 6) || op == 9;
      avs_write      = (op >= 7);
      tick();
    end
    rst_ni = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
